regfile_sb: RTL and testbench

//  Parametrised integer register file with write-back bypass and a per-register

---
 rtl/regfile_sb_pkg.sv | 14 +
 rtl/regfile_sb_counter.sv | 36 +++
 rtl/regfile_sb.sv | 123 ++++++++++++
 tb/tb_regfile_sb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the integer register file with pending-write scoreboard.
// The top module takes its parameter defaults from here.
package regfile_sb_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);
    localparam int PEND_W     = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_counter.sv
// One pending-write counter: issue increments it, write-back decrements it.
// The count saturates at its maximum and never goes below zero.
module regfile_sb_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [PEND_W-1:0] o_cnt,
    output logic              o_sat,
    output logic              o_underflow
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] r_cnt;
    logic              w_zero;

    assign w_zero      = (r_cnt == '0);
    assign o_cnt       = r_cnt;
    assign o_sat       = (r_cnt == CNT_MAX);
    // A write-back that finds nothing outstanding is reported even when an issue lands in the same cycle.
    assign o_underflow = i_dec && w_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && !o_sat) begin
            r_cnt <= r_cnt + PEND_W'(1);
        end else if (i_dec && !i_inc && !w_zero) begin
            r_cnt <= r_cnt - PEND_W'(1);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-back bypass and a per-register pending-write scoreboard.
// Decode reads and issues here; write-back writes data and retires pending writes.
module regfile_sb #(
    parameter int XLEN    = regfile_sb_pkg::XLEN,
    parameter int NREG    = regfile_sb_pkg::NREG,
    parameter int PEND_W  = regfile_sb_pkg::PEND_W,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1,
    parameter int ADDR_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    output logic [XLEN-1:0]   o_rs1_data,
    output logic [XLEN-1:0]   o_rs2_data,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy,
    input  logic              i_issue_valid,
    input  logic [ADDR_W-1:0] i_issue_rd,
    output logic              o_issue_ready,
    input  logic              i_wb_valid,
    input  logic [ADDR_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic              o_err_underflw
);

    logic [XLEN-1:0]   r_regs [NREG];
    logic              r_err;

    logic [PEND_W-1:0] w_cnt [NREG];
    logic [NREG-1:0]   w_inc;
    logic [NREG-1:0]   w_dec;
    logic [NREG-1:0]   w_sat;
    logic [NREG-1:0]   w_udf;

    logic              w_issue_r0;
    logic              w_wb_r0;
    logic              w_issue_acc;
    logic              w_wb_wr;

    logic [ADDR_W-1:0] w_raddr [2];
    logic [XLEN-1:0]   w_rdata [2];
    logic              w_rbusy [2];

    assign w_issue_r0 = (ZERO_R0 != 0) && (i_issue_rd == '0);
    assign w_wb_r0    = (ZERO_R0 != 0) && (i_wb_rd == '0);

    // A saturated counter still accepts an issue when the same register retires this cycle.
    assign o_issue_ready = w_issue_r0 || !w_sat[i_issue_rd] ||
                           (i_wb_valid && (i_wb_rd == i_issue_rd));
    assign w_issue_acc   = i_issue_valid && o_issue_ready;
    assign w_wb_wr       = i_wb_valid && !w_wb_r0;

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        if ((ZERO_R0 != 0) && (g == 0)) begin : g_r0
            assign w_inc[g] = 1'b0;
            assign w_dec[g] = 1'b0;
        end else begin : g_rn
            assign w_inc[g] = w_issue_acc && (i_issue_rd == ADDR_W'(g));
            assign w_dec[g] = i_wb_valid && (i_wb_rd == ADDR_W'(g));
        end

        regfile_sb_counter #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_inc       (w_inc[g]),
            .i_dec       (w_dec[g]),
            .o_cnt       (w_cnt[g]),
            .o_sat       (w_sat[g]),
            .o_underflow (w_udf[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_wr) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (|w_udf) begin
            r_err <= 1'b1;
        end
    end

    assign o_err_underflw = r_err;

    assign w_raddr[0] = i_rs1_addr;
    assign w_raddr[1] = i_rs2_addr;

    // Forwarded write-back data also clears busy when it retires the last outstanding write.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = r_regs[w_raddr[p]];
            w_rbusy[p] = (w_cnt[w_raddr[p]] != '0);
            if ((BYPASS != 0) && i_wb_valid && (i_wb_rd == w_raddr[p])) begin
                w_rdata[p] = i_wb_data;
                if (w_cnt[w_raddr[p]] == PEND_W'(1)) begin
                    w_rbusy[p] = 1'b0;
                end
            end
            if ((ZERO_R0 != 0) && (w_raddr[p] == '0)) begin
                w_rdata[p] = '0;
                w_rbusy[p] = 1'b0;
            end
        end
    end

    assign o_rs1_data = w_rdata[0];
    assign o_rs2_data = w_rdata[1];
    assign o_rs1_busy = w_rbusy[0];
    assign o_rs2_busy = w_rbusy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations, then random
// traffic compared every cycle against a plain array/counter model of the register file.
module tb_regfile_sb;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int PEND_W = 2;
    localparam int MAXC   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic            issue_valid, wb_valid;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_busy, rs2_busy, issue_ready, err_underflw;

    regfile_sb #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .PEND_W  (PEND_W),
        .BYPASS  (1),
        .ZERO_R0 (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rs1_addr     (rs1_addr),
        .i_rs2_addr     (rs2_addr),
        .o_rs1_data     (rs1_data),
        .o_rs2_data     (rs2_data),
        .o_rs1_busy     (rs1_busy),
        .o_rs2_busy     (rs2_busy),
        .i_issue_valid  (issue_valid),
        .i_issue_rd     (issue_rd),
        .o_issue_ready  (issue_ready),
        .i_wb_valid     (wb_valid),
        .i_wb_rd        (wb_rd),
        .i_wb_data      (wb_data),
        .o_err_underflw (err_underflw)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] m_regs [NREG];
    int              m_cnt  [NREG];
    bit              m_err;
    bit              cmp_en = 1'b0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
        if (rst) return '0;
        if (a == 0) return '0;
        if (wb_valid && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (rst || a == 0) return 1'b0;
        if (wb_valid && wb_rd == a && m_cnt[a] == 1) return 1'b0;
        return m_cnt[a] != 0;
    endfunction

    function automatic logic exp_ready();
        if (issue_rd == 0) return 1'b1;
        if (!rst && m_cnt[issue_rd] >= MAXC && !(wb_valid && wb_rd == issue_rd)) return 1'b0;
        return 1'b1;
    endfunction

    // Model state advances on the same edges as the design.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_clear();
        end else begin
            bit iss, wbv;
            iss = issue_valid && exp_ready() && issue_rd != 0;
            wbv = wb_valid && wb_rd != 0;
            if (wbv) begin
                if (m_cnt[wb_rd] == 0) m_err = 1'b1;
                m_regs[wb_rd] = wb_data;
            end
            if (!(iss && wbv && issue_rd == wb_rd)) begin
                if (iss && m_cnt[issue_rd] < MAXC) m_cnt[issue_rd]++;
                if (wbv && m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (cmp_en) begin
            check("rs1_data", rs1_data, exp_data(rs1_addr));
            check("rs2_data", rs2_data, exp_data(rs2_addr));
            check("rs1_busy", {31'b0, rs1_busy}, {31'b0, exp_busy(rs1_addr)});
            check("rs2_busy", {31'b0, rs2_busy}, {31'b0, exp_busy(rs2_addr)});
            check("issue_ready", {31'b0, issue_ready}, {31'b0, exp_ready()});
            check("err_underflw", {31'b0, err_underflw}, {31'b0, (m_err && !rst)});
        end
    end

    task automatic drive(input bit iv, input int ird, input bit wv, input int wrd,
                         input logic [XLEN-1:0] wd, input int a1, input int a2);
        @(negedge clk);
        issue_valid = iv;
        issue_rd    = AW'(ird);
        wb_valid    = wv;
        wb_rd       = AW'(wrd);
        wb_data     = wd;
        rs1_addr    = AW'(a1);
        rs2_addr    = AW'(a2);
    endtask

    function automatic int pick_addr();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, NREG-1));
        return int'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_rd = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        rs1_addr = 5'd5; rs2_addr = 5'd7;
        model_clear();
        @(negedge clk); #2;
        check("rst_rs1_data", rs1_data, 32'h0);
        check("rst_rs1_busy", {31'b0, rs1_busy}, 32'h0);
        check("rst_err", {31'b0, err_underflw}, 32'h0);
        drive(0, 0, 0, 0, 0, 5, 7);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Write x5, bypass in the write cycle, plain read afterwards.
        drive(0, 0, 1, 5, 32'hDEADBEEF, 5, 0); #2;
        check("bypass_x5", rs1_data, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 5, 0); #2;
        check("read_x5", rs1_data, 32'hDEADBEEF);
        check("err_set_x5", {31'b0, err_underflw}, 32'h1);

        // Reset in the middle of a cycle clears everything immediately.
        drive(0, 0, 0, 0, 0, 5, 5); #3;
        rst = 1'b1; #1;
        check("midrst_rs1_data", rs1_data, 32'h0);
        check("midrst_rs2_busy", {31'b0, rs2_busy}, 32'h0);
        check("midrst_err", {31'b0, err_underflw}, 32'h0);
        drive(0, 0, 0, 0, 0, 5, 5);
        rst = 1'b0;

        // r0 is never written, never pending.
        drive(1, 0, 1, 0, 32'h1234, 0, 0); #2;
        check("r0_data", rs1_data, 32'h0);
        check("r0_busy", {31'b0, rs1_busy}, 32'h0);
        check("r0_ready", {31'b0, issue_ready}, 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0); #2;
        check("r0_data_after", rs1_data, 32'h0);
        check("r0_no_err", {31'b0, err_underflw}, 32'h0);

        // Saturate x7, then issue+wb in the same cycle.
        for (int k = 0; k < 3; k++) begin
            drive(1, 7, 0, 0, 0, 0, 7); #2;
            check("x7_ready_fill", {31'b0, issue_ready}, 32'h1);
        end
        drive(1, 7, 0, 0, 0, 0, 7); #2;
        check("x7_ready_sat", {31'b0, issue_ready}, 32'h0);
        check("x7_busy_sat", {31'b0, rs2_busy}, 32'h1);
        drive(1, 7, 1, 7, 32'h77, 0, 7); #2;
        check("x7_ready_iss_wb", {31'b0, issue_ready}, 32'h1);
        check("x7_busy_iss_wb", {31'b0, rs2_busy}, 32'h1);
        drive(1, 7, 0, 0, 0, 0, 7); #2;
        check("x7_still_sat", {31'b0, issue_ready}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 7, 32'h77, 0, 7);
        end
        #2;
        check("x7_last_wb_busy", {31'b0, rs2_busy}, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 7); #2;
        check("x7_drained_busy", {31'b0, rs2_busy}, 32'h0);
        check("x7_data", rs2_data, 32'h77);

        // Single pending write retired with bypass.
        drive(1, 3, 0, 0, 0, 0, 3); #2;
        drive(0, 0, 1, 3, 32'hA5A5, 0, 3); #2;
        check("x3_wb_busy", {31'b0, rs2_busy}, 32'h0);
        check("x3_wb_data", rs2_data, 32'hA5A5);
        drive(0, 0, 0, 0, 0, 0, 3); #2;
        check("x3_after_busy", {31'b0, rs2_busy}, 32'h0);
        check("no_err_yet", {31'b0, err_underflw}, 32'h0);

        // Underflow on x9: data still written, error sticky.
        drive(0, 0, 1, 9, 32'h99, 9, 0); #2;
        check("x9_err_not_yet", {31'b0, err_underflw}, 32'h0);
        drive(0, 0, 0, 0, 0, 9, 0); #2;
        check("x9_err", {31'b0, err_underflw}, 32'h1);
        check("x9_data", rs1_data, 32'h99);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 9, 0);
        #2;
        check("x9_err_held", {31'b0, err_underflw}, 32'h1);

        // Random traffic with occasional mid-cycle resets.
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 1) == 1, pick_addr(), $urandom_range(0, 9) < 4,
                  pick_addr(), $urandom, pick_addr(), pick_addr());
            if (rst) rst = 1'b0;
            if ($urandom_range(0, 199) == 0) begin
                #3;
                rst = 1'b1;
            end
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk); #2;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
